// File: rtl/core161c_pkg.sv
// Shared definitions for the core161c 16K x 36 core memory module:
// bus field widths, controller state encoding and core geometry.
package core161c_pkg;

  localparam int WORD_W     = 36;
  localparam int ADDR_W     = 15;
  localparam int SEL_W      = 4;
  localparam int NUM_PORTS  = 4;
  localparam int PORT_W     = 2;
  localparam int CORE_AW    = 14;
  localparam int CORE_WORDS = 'o40000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_READ,
    ST_WAITWR,
    ST_DONE
  } state_t;

endpackage

// File: rtl/core161c_arb.sv
// Four-way fixed-priority selector: lowest-numbered requesting port wins.
module core161c_arb
  import core161c_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  output logic                 valid,
  output logic [PORT_W-1:0]    port
);

  always_comb begin
    valid = |req;
    port  = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) port = PORT_W'(i);
    end
  end

endmodule

// File: rtl/core161c.sv
// core161c: 16K x 36 core memory on the PDP-10 memory bus, four processor
// ports, read / write / read-modify-write cycles, OR-tied read data.
module core161c
  import core161c_pkg::*;
#(
  parameter logic [3:0] memsel_p0 = 4'b0000,
  parameter logic [3:0] memsel_p1 = 4'b0000,
  parameter logic [3:0] memsel_p2 = 4'b0000,
  parameter logic [3:0] memsel_p3 = 4'b0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         power,
  input  logic         sw_single_step,
  input  logic         sw_restart,

  input  logic         membus_rd_rq_p0,
  input  logic         membus_wr_rq_p0,
  input  logic         membus_rq_cyc_p0,
  input  logic         membus_wr_rs_p0,
  input  logic [21:35] membus_ma_p0,
  input  logic [18:21] membus_sel_p0,
  input  logic         membus_fmc_select_p0,
  input  logic [0:35]  membus_mb_in_p0,
  output logic [0:35]  membus_mb_out_p0,
  output logic         membus_addr_ack_p0,
  output logic         membus_rd_rs_p0,

  input  logic         membus_rd_rq_p1,
  input  logic         membus_wr_rq_p1,
  input  logic         membus_rq_cyc_p1,
  input  logic         membus_wr_rs_p1,
  input  logic [21:35] membus_ma_p1,
  input  logic [18:21] membus_sel_p1,
  input  logic         membus_fmc_select_p1,
  input  logic [0:35]  membus_mb_in_p1,
  output logic [0:35]  membus_mb_out_p1,
  output logic         membus_addr_ack_p1,
  output logic         membus_rd_rs_p1,

  input  logic         membus_rd_rq_p2,
  input  logic         membus_wr_rq_p2,
  input  logic         membus_rq_cyc_p2,
  input  logic         membus_wr_rs_p2,
  input  logic [21:35] membus_ma_p2,
  input  logic [18:21] membus_sel_p2,
  input  logic         membus_fmc_select_p2,
  input  logic [0:35]  membus_mb_in_p2,
  output logic [0:35]  membus_mb_out_p2,
  output logic         membus_addr_ack_p2,
  output logic         membus_rd_rs_p2,

  input  logic         membus_rd_rq_p3,
  input  logic         membus_wr_rq_p3,
  input  logic         membus_rq_cyc_p3,
  input  logic         membus_wr_rs_p3,
  input  logic [21:35] membus_ma_p3,
  input  logic [18:21] membus_sel_p3,
  input  logic         membus_fmc_select_p3,
  input  logic [0:35]  membus_mb_in_p3,
  output logic [0:35]  membus_mb_out_p3,
  output logic         membus_addr_ack_p3,
  output logic         membus_rd_rs_p3
);

  localparam logic [NUM_PORTS*SEL_W-1:0] memsel_all = {memsel_p3, memsel_p2, memsel_p1, memsel_p0};

  logic [0:WORD_W-1] core [CORE_WORDS];

  logic [NUM_PORTS-1:0]                rd_rq, wr_rq, rq_cyc, wr_rs, fmc;
  logic [NUM_PORTS-1:0][21:35]         ma_arr;
  logic [NUM_PORTS-1:0][SEL_W-1:0]     sel_arr;
  logic [NUM_PORTS-1:0][0:WORD_W-1]    mb_in_arr;
  logic [NUM_PORTS-1:0][0:WORD_W-1]    mb_out_arr;
  logic [NUM_PORTS-1:0]                addr_ack, rd_rs, req;

  state_t              state_reg, state_next;
  logic [PORT_W-1:0]   active_reg;
  logic [CORE_AW-1:0]  addr_reg;
  logic                rd_reg, wr_reg;
  logic                hold_reg, hold_next;
  logic                restart_d_reg;
  logic [0:WORD_W-1]   read_data_reg;

  logic                grant_valid;
  logic [PORT_W-1:0]   grant_port;
  logic                can_accept, load, write_en, hold_set;
  logic                act_cyc, act_wr_rs;
  logic [0:WORD_W-1]   act_mb_in;
  logic                unused_ma21;

  assign rd_rq     = {membus_rd_rq_p3, membus_rd_rq_p2, membus_rd_rq_p1, membus_rd_rq_p0};
  assign wr_rq     = {membus_wr_rq_p3, membus_wr_rq_p2, membus_wr_rq_p1, membus_wr_rq_p0};
  assign rq_cyc    = {membus_rq_cyc_p3, membus_rq_cyc_p2, membus_rq_cyc_p1, membus_rq_cyc_p0};
  assign wr_rs     = {membus_wr_rs_p3, membus_wr_rs_p2, membus_wr_rs_p1, membus_wr_rs_p0};
  assign fmc       = {membus_fmc_select_p3, membus_fmc_select_p2,
                      membus_fmc_select_p1, membus_fmc_select_p0};
  assign ma_arr    = {membus_ma_p3, membus_ma_p2, membus_ma_p1, membus_ma_p0};
  assign sel_arr   = {membus_sel_p3, membus_sel_p2, membus_sel_p1, membus_sel_p0};
  assign mb_in_arr = {membus_mb_in_p3, membus_mb_in_p2, membus_mb_in_p1, membus_mb_in_p0};
  assign {membus_mb_out_p3, membus_mb_out_p2, membus_mb_out_p1, membus_mb_out_p0} = mb_out_arr;
  assign {membus_addr_ack_p3, membus_addr_ack_p2, membus_addr_ack_p1, membus_addr_ack_p0} = addr_ack;
  assign {membus_rd_rs_p3, membus_rd_rs_p2, membus_rd_rs_p1, membus_rd_rs_p0} = rd_rs;

  // ma[21] selects the other half of a 32K space; this module only holds 16K.
  assign unused_ma21 = ma_arr[0][21] ^ ma_arr[1][21] ^ ma_arr[2][21] ^ ma_arr[3][21];

  assign can_accept = power & (state_reg == ST_IDLE) & ~hold_reg;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign req[gi] = rq_cyc[gi] & ~fmc[gi] & (rd_rq[gi] | wr_rq[gi]) & can_accept
                   & (sel_arr[gi] == memsel_all[gi*SEL_W +: SEL_W]);
    assign addr_ack[gi]   = power & (state_reg == ST_ACK)  & (active_reg == PORT_W'(gi));
    assign rd_rs[gi]      = power & (state_reg == ST_READ) & (active_reg == PORT_W'(gi));
    assign mb_out_arr[gi] = rd_rs[gi] ? read_data_reg : '0;
  end

  core161c_arb u_arb (
    .req   (req),
    .valid (grant_valid),
    .port  (grant_port)
  );

  assign act_cyc   = rq_cyc[active_reg];
  assign act_wr_rs = wr_rs[active_reg];
  assign act_mb_in = mb_in_arr[active_reg];

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    write_en   = 1'b0;
    hold_set   = 1'b0;
    unique case (state_reg)
      ST_IDLE:   if (grant_valid) begin
                   load       = 1'b1;
                   state_next = ST_ACK;
                 end
      ST_ACK:    state_next = rd_reg ? ST_READ : ST_WAITWR;
      ST_READ:   state_next = wr_reg ? ST_WAITWR : ST_DONE;
      ST_WAITWR: if (act_wr_rs) begin
                   write_en   = 1'b1;
                   state_next = ST_DONE;
                 end else if (!act_cyc) begin
                   state_next = ST_DONE;
                 end
      ST_DONE:   if (!act_cyc) begin
                   state_next = ST_IDLE;
                   hold_set   = sw_single_step;
                 end
      default:   state_next = ST_IDLE;
    endcase
    if (!power) begin
      state_next = ST_IDLE;
      load       = 1'b0;
      write_en   = 1'b0;
      hold_set   = 1'b0;
    end
  end

  always_comb begin
    hold_next = hold_reg;
    if (hold_set)                         hold_next = 1'b1;
    else if (sw_restart && !restart_d_reg) hold_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      active_reg    <= '0;
      addr_reg      <= '0;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
      hold_reg      <= 1'b0;
      restart_d_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      restart_d_reg <= sw_restart;
      if (load) begin
        active_reg <= grant_port;
        addr_reg   <= ma_arr[grant_port][22:35];
        rd_reg     <= rd_rq[grant_port];
        wr_reg     <= wr_rq[grant_port];
      end
    end
  end

  // Core array has no reset so it maps to block RAM; read data is registered
  // during ACK and presented during READ.
  always_ff @(posedge clk) begin
    if (write_en) core[addr_reg] <= act_mb_in;
    read_data_reg <= core[addr_reg];
  end

endmodule

// File: tb/tb_core161c.sv
// Directed bench for core161c: read, write, RMW, select filtering, priority,
// single-step hold, power loss and reset in mid-cycle.
module tb_core161c;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, power, sw_single_step, sw_restart;
  logic        rd_rq [4];
  logic        wr_rq [4];
  logic        rq_cyc [4];
  logic        wr_rs [4];
  logic        fmc [4];
  logic [21:35] ma [4];
  logic [18:21] sel [4];
  logic [0:35]  mb_in [4];
  logic [0:35]  mb_out [4];
  logic         addr_ack [4];
  logic         rd_rs [4];

  int vectors = 0;
  int miscompares = 0;

  core161c dut (
    .clk(clk), .reset(reset), .power(power),
    .sw_single_step(sw_single_step), .sw_restart(sw_restart),
    .membus_rd_rq_p0(rd_rq[0]), .membus_wr_rq_p0(wr_rq[0]), .membus_rq_cyc_p0(rq_cyc[0]),
    .membus_wr_rs_p0(wr_rs[0]), .membus_ma_p0(ma[0]), .membus_sel_p0(sel[0]),
    .membus_fmc_select_p0(fmc[0]), .membus_mb_in_p0(mb_in[0]), .membus_mb_out_p0(mb_out[0]),
    .membus_addr_ack_p0(addr_ack[0]), .membus_rd_rs_p0(rd_rs[0]),
    .membus_rd_rq_p1(rd_rq[1]), .membus_wr_rq_p1(wr_rq[1]), .membus_rq_cyc_p1(rq_cyc[1]),
    .membus_wr_rs_p1(wr_rs[1]), .membus_ma_p1(ma[1]), .membus_sel_p1(sel[1]),
    .membus_fmc_select_p1(fmc[1]), .membus_mb_in_p1(mb_in[1]), .membus_mb_out_p1(mb_out[1]),
    .membus_addr_ack_p1(addr_ack[1]), .membus_rd_rs_p1(rd_rs[1]),
    .membus_rd_rq_p2(rd_rq[2]), .membus_wr_rq_p2(wr_rq[2]), .membus_rq_cyc_p2(rq_cyc[2]),
    .membus_wr_rs_p2(wr_rs[2]), .membus_ma_p2(ma[2]), .membus_sel_p2(sel[2]),
    .membus_fmc_select_p2(fmc[2]), .membus_mb_in_p2(mb_in[2]), .membus_mb_out_p2(mb_out[2]),
    .membus_addr_ack_p2(addr_ack[2]), .membus_rd_rs_p2(rd_rs[2]),
    .membus_rd_rq_p3(rd_rq[3]), .membus_wr_rq_p3(wr_rq[3]), .membus_rq_cyc_p3(rq_cyc[3]),
    .membus_wr_rs_p3(wr_rs[3]), .membus_ma_p3(ma[3]), .membus_sel_p3(sel[3]),
    .membus_fmc_select_p3(fmc[3]), .membus_mb_in_p3(mb_in[3]), .membus_mb_out_p3(mb_out[3]),
    .membus_addr_ack_p3(addr_ack[3]), .membus_rd_rs_p3(rd_rs[3])
  );

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int p, input logic [13:0] a, input logic [35:0] exp);
    ma[p] = {1'b0, a}; sel[p] = 4'b0000; rd_rq[p] = 1'b1; rq_cyc[p] = 1'b1;
    tick();
    chk($sformatf("rd%0d_ack", p), 36'(addr_ack[p]), 36'd1);
    chk($sformatf("rd%0d_early_rs", p), 36'(rd_rs[p]), 36'd0);
    chk($sformatf("rd%0d_early_mb", p), mb_out[p], 36'd0);
    tick();
    chk($sformatf("rd%0d_rs", p), 36'(rd_rs[p]), 36'd1);
    chk($sformatf("rd%0d_data", p), mb_out[p], exp);
    chk($sformatf("rd%0d_ack_pulse", p), 36'(addr_ack[p]), 36'd0);
    tick();
    chk($sformatf("rd%0d_rs_pulse", p), 36'(rd_rs[p]), 36'd0);
    chk($sformatf("rd%0d_mb_after", p), mb_out[p], 36'd0);
    rq_cyc[p] = 1'b0; rd_rq[p] = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_write(input int p, input logic [13:0] a, input logic [35:0] data);
    ma[p] = {1'b0, a}; sel[p] = 4'b0000; wr_rq[p] = 1'b1; rq_cyc[p] = 1'b1;
    tick();
    chk($sformatf("wr%0d_ack", p), 36'(addr_ack[p]), 36'd1);
    tick();
    chk($sformatf("wr%0d_no_rs", p), 36'(rd_rs[p]), 36'd0);
    chk($sformatf("wr%0d_mb_quiet", p), mb_out[p], 36'd0);
    mb_in[p] = data; wr_rs[p] = 1'b1;
    tick();
    wr_rs[p] = 1'b0; mb_in[p] = '0;
    chk($sformatf("wr%0d_mb_done", p), mb_out[p], 36'd0);
    rq_cyc[p] = 1'b0; wr_rq[p] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic seen;
    reset = 1'b1; power = 1'b1; sw_single_step = 1'b0; sw_restart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_rq[i] = 1'b0; wr_rq[i] = 1'b0; rq_cyc[i] = 1'b0; wr_rs[i] = 1'b0;
      fmc[i] = 1'b0; ma[i] = '0; sel[i] = '0; mb_in[i] = '0;
    end
    dut.core[14'o300] = 36'o123456111222;
    dut.core[14'o141] = 36'o0;
    dut.core[14'o142] = 36'o2;
    dut.core[14'o5]   = 36'o555;
    dut.core[14'o400] = 36'o1111;
    dut.core[14'o401] = 36'o2222;
    dut.core[14'o500] = 36'o7;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_ack%0d", i), 36'(addr_ack[i]), 36'd0);
      chk($sformatf("reset_rs%0d", i), 36'(rd_rs[i]), 36'd0);
      chk($sformatf("reset_mb%0d", i), mb_out[i], 36'd0);
    end
    reset = 1'b0;
    tick();

    // Plain read, write then readback, read-modify-write.
    do_read(0, 14'o300, 36'o123456111222);
    do_read(0, 14'o300, 36'o123456111222);
    do_write(0, 14'o141, 36'o777740000100);
    do_read(0, 14'o141, 36'o777740000100);

    ma[0] = 15'o142; rd_rq[0] = 1'b1; wr_rq[0] = 1'b1; rq_cyc[0] = 1'b1;
    tick();
    chk("rmw_ack", 36'(addr_ack[0]), 36'd1);
    tick();
    chk("rmw_rs", 36'(rd_rs[0]), 36'd1);
    chk("rmw_data", mb_out[0], 36'o2);
    tick();
    chk("rmw_wait_mb", mb_out[0], 36'd0);
    mb_in[0] = 36'o3; wr_rs[0] = 1'b1;
    tick();
    wr_rs[0] = 1'b0; mb_in[0] = '0; rq_cyc[0] = 1'b0; rd_rq[0] = 1'b0; wr_rq[0] = 1'b0;
    tick(); tick();
    do_read(0, 14'o142, 36'o3);

    // Fast-memory accesses and foreign module numbers are ignored.
    ma[0] = 15'o5; rd_rq[0] = 1'b1; rq_cyc[0] = 1'b1; fmc[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); seen |= addr_ack[0] | rd_rs[0]; end
    chk("fmc_ignored", 36'(seen), 36'd0);
    fmc[0] = 1'b0; sel[0] = 4'b0001;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); seen |= addr_ack[0] | rd_rs[0]; end
    chk("sel_ignored", 36'(seen), 36'd0);
    rq_cyc[0] = 1'b0; rd_rq[0] = 1'b0; sel[0] = 4'b0000;
    tick();
    do_read(0, 14'o5, 36'o555);

    // p0 and p2 together: p0 first, p2 only once p0 releases the bus.
    ma[0] = 15'o400; rd_rq[0] = 1'b1; rq_cyc[0] = 1'b1;
    ma[2] = 15'o401; rd_rq[2] = 1'b1; rq_cyc[2] = 1'b1;
    tick();
    chk("pri_ack0", 36'(addr_ack[0]), 36'd1);
    chk("pri_ack2_low", 36'(addr_ack[2]), 36'd0);
    tick();
    chk("pri_data0", mb_out[0], 36'o1111);
    chk("pri_mb2_quiet", mb_out[2], 36'd0);
    tick();
    chk("pri_done_ack2", 36'(addr_ack[2]), 36'd0);
    rq_cyc[0] = 1'b0; rd_rq[0] = 1'b0;
    tick();
    chk("pri_idle_ack2", 36'(addr_ack[2]), 36'd0);
    tick();
    chk("pri_ack2", 36'(addr_ack[2]), 36'd1);
    tick();
    chk("pri_rs2", 36'(rd_rs[2]), 36'd1);
    chk("pri_data2", mb_out[2], 36'o2222);
    rq_cyc[2] = 1'b0; rd_rq[2] = 1'b0;
    tick(); tick();

    // Single step: hold after a completed cycle until sw_restart rises.
    sw_single_step = 1'b1;
    do_read(0, 14'o500, 36'o7);
    ma[1] = 15'o300; rd_rq[1] = 1'b1; rq_cyc[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); seen |= addr_ack[1]; end
    chk("step_hold", 36'(seen), 36'd0);
    sw_single_step = 1'b0; sw_restart = 1'b1;
    tick();
    chk("step_release_edge", 36'(addr_ack[1]), 36'd0);
    tick();
    chk("step_ack1", 36'(addr_ack[1]), 36'd1);
    tick();
    chk("step_data1", mb_out[1], 36'o123456111222);
    rq_cyc[1] = 1'b0; rd_rq[1] = 1'b0; sw_restart = 1'b0;
    tick(); tick();

    // Power loss in mid-cycle: outputs drop at once and the cycle is lost.
    ma[0] = 15'o300; rd_rq[0] = 1'b1; rq_cyc[0] = 1'b1;
    tick();
    chk("pwr_ack", 36'(addr_ack[0]), 36'd1);
    power = 1'b0;
    #1;
    chk("pwr_ack_forced", 36'(addr_ack[0]), 36'd0);
    tick();
    chk("pwr_no_rs", 36'(rd_rs[0]), 36'd0);
    chk("pwr_no_mb", mb_out[0], 36'd0);
    rq_cyc[0] = 1'b0; rd_rq[0] = 1'b0; power = 1'b1;
    tick();
    chk("pwr_idle", 36'(addr_ack[0]), 36'd0);

    // Reset during WAITWR with wr_rs asserted: no write, outputs cleared.
    ma[3] = 15'o141; wr_rq[3] = 1'b1; rq_cyc[3] = 1'b1;
    tick();
    chk("rst_ack3", 36'(addr_ack[3]), 36'd1);
    tick();
    reset = 1'b1; mb_in[3] = 36'o1; wr_rs[3] = 1'b1;
    #1;
    chk("rst_ack3_low", 36'(addr_ack[3]), 36'd0);
    chk("rst_mb3_low", mb_out[3], 36'd0);
    tick();
    reset = 1'b0; wr_rs[3] = 1'b0; mb_in[3] = '0; rq_cyc[3] = 1'b0; wr_rq[3] = 1'b0;
    tick();
    chk("rst_rs3_low", 36'(rd_rs[3]), 36'd0);
    do_read(0, 14'o141, 36'o777740000100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
